// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory master.
// Size encodings follow the execute-stage request format; size 3 is never legal.
package lsu_pkg;

  localparam int LSU_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load lanes from a bus word and
// merges sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LSU_WIDTH-1:0] i_word,
  input  logic [LSU_WIDTH-1:0] i_wdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  output logic [LSU_WIDTH-1:0] o_load_data,
  output logic [LSU_WIDTH-1:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_data = i_word;
    endcase

    // Untouched lanes keep the old word so the full-word write is a true RMW.
    o_merge_data = i_word;
    case (i_size)
      SZ_BYTE: o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata[15:0];
        else              o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Word-bus initiator for execute-stage loads/stores: word-aligned transfers,
// read-modify-write for sub-word stores, misalignment and timeout errors.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wstrobe,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_done,
  output lsu_state_t       dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t       r_state;
  logic             r_write;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_addr_lo;
  logic [WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0] r_cnt;

  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [WIDTH-1:0] r_resp_rdata;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_mem_wstrobe;

  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_merge_data;
  logic             w_misaligned;
  logic             w_timeout;

  lsu_align u_align (
    .i_word      (mem_rdata),
    .i_wdata     (r_wdata),
    .i_addr_lo   (r_addr_lo),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .o_load_data (w_load_data),
    .o_merge_data(w_merge_data)
  );

  always_comb begin
    w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    // A completing mem_done in the limit cycle takes priority over the timeout.
    w_timeout    = (TIMEOUT_CYCLES > 0) && !mem_done && (r_cnt == CNT_LIMIT);
  end

  // Request handshake: a request transfers on a rising edge where req_valid
  // and req_ready are both high; req_ready is high only in IDLE, so inputs are
  // ignored while a transaction is in flight. Responses cannot be stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_size        <= 2'd0;
      r_signed      <= 1'b0;
      r_addr_lo     <= 2'd0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrobe <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_addr_lo   <= req_addr[1:0];
            r_wdata     <= req_wdata;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (w_misaligned) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!req_write || (req_size != SZ_WORD)) begin
              r_state    <= ST_RD;
              r_mem_addr <= {req_addr[WIDTH-1:2], 2'b00};
            end else begin
              r_state       <= ST_WR;
              r_mem_addr    <= {req_addr[WIDTH-1:2], 2'b00};
              r_mem_wdata   <= req_wdata;
              r_mem_wstrobe <= 1'b1;
            end
          end
        end

        ST_RD: begin
          if (mem_done) begin
            r_cnt <= '0;
            if (!r_write) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load_data;
              r_mem_addr   <= '0;
            end else begin
              r_state       <= ST_WR;
              r_mem_wdata   <= w_merge_data;
              r_mem_wstrobe <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
          end else if (TIMEOUT_CYCLES > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_WR: begin
          if (mem_done || w_timeout) begin
            r_state       <= ST_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_err    <= !mem_done;
            r_resp_rdata  <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrobe <= 1'b0;
          end else if (TIMEOUT_CYCLES > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrobe = r_mem_wstrobe;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: transaction-level model with a 16-word memory window
// at 0x40..0x7F, per-cycle output compare, directed cases and random traffic.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wstrobe, mem_done;
  lsu_state_t  dbg_state;

  logic [31:0] bus_mem [16];
  logic [31:0] ref_mem [16];

  assign mem_rdata = bus_mem[mem_addr[5:2]];

  lsu_mem_master #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrobe(mem_wstrobe), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];   // expected write words, oldest first
  bit          m_ph_q[$];  // remaining bus phases: 0 = read, 1 = write
  bit          m_live = 0;
  bit          m_resp = 0;
  bit          m_resp_err;
  logic [31:0] m_resp_rdata;
  logic [31:0] m_addr;
  int          m_zero;

  int          cyc = 0, acc_cyc = 0, resp_cnt = 0;
  int          obs_lat, obs_wr_cnt, obs_wstb, obs_bus;
  logic [31:0] obs_rdata, obs_wr_data, obs_wr_addr;
  logic        obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no event expected one within bound (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] off, logic [1:0] sz, logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_val(logic [31:0] w, logic [31:0] wd, logic [1:0] off, logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * off;
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * off[1];
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic model_accept();
    bit mis;
    logic [31:0] w;
    mis = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    w = ref_mem[req_addr[5:2]];
    m_addr = {req_addr[31:2], 2'b00};
    m_zero = 0;
    m_resp_err = 0;
    m_resp_rdata = 32'h0;
    acc_cyc = cyc;
    obs_wr_cnt = 0;
    obs_wstb = 0;
    obs_bus = 0;
    if (mis) begin
      m_resp = 1;
      m_resp_err = 1;
    end else if (!req_write) begin
      m_ph_q.push_back(1'b0);
      m_resp_rdata = load_val(w, req_addr[1:0], req_size, req_signed);
    end else if (req_size == 2'd2) begin
      m_ph_q.push_back(1'b1);
      exp_q.push_back(req_wdata);
    end else begin
      m_ph_q.push_back(1'b0);
      m_ph_q.push_back(1'b1);
      exp_q.push_back(merge_val(w, req_wdata, req_addr[1:0], req_size));
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (m_live) begin
        if (m_ph_q.size() > 0) begin
          chk("ready_busy", req_ready, 0);
          chk("resp_valid_busy", resp_valid, 0);
          chk("mem_addr_bus", mem_addr, m_addr);
          chk("wstrobe_bus", mem_wstrobe, m_ph_q[0]);
          chk("wdata_bus", mem_wdata, m_ph_q[0] ? exp_q[0] : 32'h0);
        end else if (m_resp) begin
          chk("ready_resp", req_ready, 0);
          chk("resp_valid", resp_valid, 1);
          chk("resp_err", resp_err, m_resp_err);
          chk("resp_rdata", resp_rdata, m_resp_rdata);
          chk("wstrobe_resp", mem_wstrobe, 0);
          chk("wdata_resp", mem_wdata, 0);
        end else begin
          chk("ready_idle", req_ready, 1);
          chk("resp_valid_idle", resp_valid, 0);
          chk("mem_addr_idle", mem_addr, 0);
          chk("wstrobe_idle", mem_wstrobe, 0);
          chk("wdata_idle", mem_wdata, 0);
        end
      end

      if (resp_valid === 1'b1) begin
        resp_cnt++;
        obs_lat = cyc - acc_cyc;
        obs_rdata = resp_rdata;
        obs_err = resp_err;
      end
      if (mem_wstrobe === 1'b1) obs_wstb++;
      if (mem_addr !== 32'h0 || mem_wstrobe === 1'b1) obs_bus++;
      if (mem_wstrobe === 1'b1 && mem_done) begin
        bus_mem[mem_addr[5:2]] = mem_wdata;
        obs_wr_cnt++;
        obs_wr_data = mem_wdata;
        obs_wr_addr = mem_addr;
      end

      if (rst) begin
        // A write completing on the reset edge still reached memory.
        if (m_ph_q.size() > 0 && m_ph_q[0] && mem_done) ref_mem[m_addr[5:2]] = exp_q[0];
        m_live = 1;
        m_ph_q.delete();
        exp_q.delete();
        m_resp = 0;
        m_zero = 0;
      end else if (m_live) begin
        if (m_ph_q.size() > 0) begin
          if (mem_done) begin
            if (m_ph_q[0]) ref_mem[m_addr[5:2]] = exp_q.pop_front();
            m_ph_q.delete(0);
            m_zero = 0;
            if (m_ph_q.size() == 0) m_resp = 1;
          end else begin
            m_zero++;
            if (m_zero == TO) begin
              m_ph_q.delete();
              exp_q.delete();
              m_resp = 1;
              m_resp_err = 1;
              m_resp_rdata = 32'h0;
            end
          end
        end else if (m_resp) begin
          m_resp = 0;
        end else if (req_valid) begin
          model_accept();
        end
      end
    end
  end

  // ---------------- driver ----------------
  int done_mode = 0;   // 0: tied 1, 1: tied 0, 2: random
  bit done_q[$];

  task automatic tick();
    @(negedge clk);
    if (done_q.size() > 0) mem_done = done_q.pop_front();
    else if (done_mode == 0) mem_done = 1'b1;
    else if (done_mode == 1) mem_done = 1'b0;
    else mem_done = 1'($urandom_range(0, 1));
  endtask

  task automatic set_mem(input int idx, input logic [31:0] v);
    bus_mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      tick();
      req_valid = 1'b0;
      if (req_ready === 1'b1) begin
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        ok = 1;
      end
    end
    if (!ok) bound_fail("send_accept");
  endtask

  task automatic finish_resp();
    int start;
    int n;
    start = resp_cnt;
    n = 0;
    do begin
      tick();
      req_valid = 1'b0;
      n++;
    end while (resp_cnt == start && n < 40);
    if (resp_cnt == start) bound_fail("resp_wait");
  endtask

  initial begin
    int start;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    mem_done = 1'b0;
    for (int i = 0; i < 16; i++) set_mem(i, $urandom());
    repeat (3) tick();
    rst = 1'b0;
    tick();
    #2;
    chk("reset_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_wstrobe", mem_wstrobe, 0);
    chk("reset_mem_addr", mem_addr, 0);

    // Word load
    set_mem(0, 32'hDEAD_BEEF);
    send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    finish_resp();
    chk("ldw_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("ldw_err", obs_err, 0);
    chk("ldw_latency", obs_lat, 2);
    chk("ldw_no_write", obs_wstb, 0);

    // Byte loads from the top lane
    set_mem(0, 32'h80FF_0102);
    send(1'b0, 2'd0, 1'b1, 32'h43, 32'h0);
    finish_resp();
    chk("ldb_signed", obs_rdata, 32'hFFFF_FF80);
    send(1'b0, 2'd0, 1'b0, 32'h43, 32'h0);
    finish_resp();
    chk("ldb_unsigned", obs_rdata, 32'h0000_0080);

    // Half store read-modify-write
    set_mem(0, 32'h1122_3344);
    send(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_ABCD);
    finish_resp();
    chk("sth_writes", obs_wr_cnt, 1);
    chk("sth_wdata", obs_wr_data, 32'hABCD_3344);
    chk("sth_waddr", obs_wr_addr, 32'h40);
    chk("sth_latency", obs_lat, 3);

    // Misaligned word load
    send(1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    finish_resp();
    chk("mis_err", obs_err, 1);
    chk("mis_rdata", obs_rdata, 0);
    chk("mis_latency", obs_lat, 1);
    chk("mis_no_bus", obs_bus, 0);

    // Word store timing out
    done_mode = 1;
    send(1'b1, 2'd2, 1'b0, 32'h48, 32'h1234_5678);
    finish_resp();
    chk("to_err", obs_err, 1);
    chk("to_wstrobe_cycles", obs_wstb, 4);
    chk("to_no_write", obs_wr_cnt, 0);
    chk("to_latency", obs_lat, 5);

    // mem_done arriving in the limit cycle completes normally
    send(1'b1, 2'd2, 1'b0, 32'h48, 32'hCAFE_F00D);
    done_q.push_back(1'b0);
    done_q.push_back(1'b0);
    done_q.push_back(1'b0);
    done_q.push_back(1'b1);
    finish_resp();
    chk("lim_err", obs_err, 0);
    chk("lim_wstrobe_cycles", obs_wstb, 4);
    chk("lim_writes", obs_wr_cnt, 1);
    chk("lim_wdata", obs_wr_data, 32'hCAFE_F00D);
    chk("lim_latency", obs_lat, 5);

    // Reset while a write is stalled
    send(1'b1, 2'd2, 1'b0, 32'h4C, 32'h55AA_55AA);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rst_wstrobe", mem_wstrobe, 0);
    chk("rst_ready", req_ready, 1);
    start = resp_cnt;
    repeat (6) tick();
    chk("rst_no_resp", resp_cnt - start, 0);
    done_mode = 0;

    // Random traffic, including requests presented while busy and stray resets
    done_mode = 2;
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr = 32'h40 + 32'($urandom_range(0, 63));
      req_wdata = $urandom();
    end
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    done_mode = 0;
    repeat (12) tick();
    for (int i = 0; i < 16; i++) chk("mem_final", bus_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got time %0t expected completion earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the core's word-wide memory bus (mem_addr / mem_wdata / mem_wstrobe / mem_rdata / mem_done).
- Accepts byte, halfword and word load/store requests from the execute stage.
- Issues word-aligned bus transactions and performs read-modify-write for sub-word stores, because the bus only writes whole words.
- Returns load data extracted and extended, or an error for misaligned accesses and bus timeouts.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for mem_done in one bus state; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- req_signed  in  1  sign-extend load data.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  misaligned access or timeout; valid only with resp_valid.
- resp_rdata  out  WIDTH  load result; 0 for stores and errors.
- mem_addr  out  WIDTH  {addr[31:2],2'b00}.
- mem_wdata  out  WIDTH  merged write word.
- mem_wstrobe  out  1  write enable.
- mem_rdata  in  WIDTH  read word.
- mem_done  in  1  transaction complete.

Behaviour:
- Reset values: all outputs 0, except req_ready = 1; state IDLE; timeout counter 0. Reset mid-transaction aborts immediately, so mem_wstrobe is 0 from the reset edge onward and no response is produced.
- States: IDLE, RD, WR, RESP.
- req_ready is 1 only in IDLE. On accept, latch write, size, signed, addr and wdata. Inputs are ignored outside IDLE.
- Misaligned means: size 3; half with addr[0] = 1; word with addr[1:0] ≠ 0. A misaligned request goes IDLE→RESP with resp_err = 1 and no bus activity, so the response appears 1 cycle after accept.
- Load and sub-word store go IDLE→RD. Word store goes IDLE→WR.
- RD:
  - mem_addr is driven and mem_wstrobe = 0.
  - On mem_done, capture mem_rdata.
  - Load: → RESP with resp_rdata = extracted lane (byte at addr[1:0], half at addr[1]), sign- or zero-extended per req_signed.
  - Sub-word store: → WR, with the merge word = captured word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
- WR:
  - mem_wstrobe = 1 and mem_wdata = merge word (word store: req_wdata), held stable until mem_done.
  - On mem_done → RESP. mem_wstrobe is 0 in the following cycle.
  - Exactly one write per store.
- RESP: resp_valid = 1 for exactly one cycle, then → IDLE. There is no response backpressure.
- mem_wdata = 0 outside WR. mem_addr holds the latched address in RD/WR and is 0 in IDLE.
- Latency with mem_done tied 1:
  - load: accept T, RD T+1, resp T+2.
  - word store: resp T+2.
  - sub-word store: resp T+3.
  - Each stall cycle of mem_done adds 1.
- Timeout, when TIMEOUT_CYCLES > 0:
  - Counter clears on entry to RD/WR and increments each cycle that mem_done = 0.
  - On reaching TIMEOUT_CYCLES → RESP with resp_err = 1, and mem_wstrobe drops.
  - mem_done in the same cycle as the limit wins, i.e. the access completes normally.
- A new request can be accepted in the cycle after resp_valid, i.e. back-to-back through IDLE.

Decomposition:
- Package lsu_pkg:
  - mem_size_t enum (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2).
  - lsu_state_t enum.
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_align, purely combinational, with two jobs:
  - load lane extract/extend: word, addr[1:0], size, signed → rdata.
  - store lane merge: old word, new data, addr[1:0], size → merged word.
- The FSM, timeout counter and latches live in lsu_mem_master.

Test Plan:
- Load word, mem_done = 1, memory[0x40>>2] = 0xDEADBEEF; req addr 0x40 size 2 → resp_valid at T+2, resp_rdata 0xDEADBEEF, resp_err 0, mem_wstrobe never high.
- Signed byte load from addr 0x43, memory word 0x80FF_0102 → resp_rdata 0xFFFFFF80. Unsigned → 0x00000080.
- Half store 0xABCD to addr 0x42, memory word 0x11223344 → exactly one write of 0xABCD3344 to mem_addr 0x40, resp at T+3.
- Misaligned word load at 0x41 → resp_err = 1 at T+1, resp_rdata 0, mem_addr/mem_wstrobe stay 0.
- TIMEOUT_CYCLES = 4, mem_done held 0 during a word store → mem_wstrobe high 4 cycles then low, resp_err = 1. Repeat with mem_done = 1 on the 4th cycle → resp_err = 0.
- rst asserted in WR with mem_done = 0 → mem_wstrobe 0 and req_ready 1 next cycle, no resp_valid.
